missile_fire_controller: RTL and testbench

Sequencing and arbitration block between the player's fire input and a pool of `NUM_MISSILES` missile movement instances. It turns a fire-button level into one-cycle launch pulses and allocates each shot to a free missile slot in round-robin order. It enforces a per-shot cooldown measured in frames and keeps a slot reserved until that missile reports itself active. It sits beside the player spaceship logic. Each `shooting_pulse[i]` drives the shooting input of missile instance i, and each `missile_active[i]` returns from it.

---
 rtl/missile_fire_controller.sv | 166 ++++++++++++++++
 tb/tb_missile_fire_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/missile_fire_controller.sv
// ============================================================================
// Module   : missile_fire_controller
// Purpose  : Turns the fire button into one-hot launch pulses, round-robin
//            slot allocation, frame-based cooldown and launch reservations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module missile_fire_controller #(
  parameter int NUM_MISSILES    = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RESERVE_TIMEOUT = 2,
  parameter int AUTO_FIRE       = 0
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    enable,
  input  logic                    fire_req,
  input  logic [NUM_MISSILES-1:0] missile_active,
  output logic [NUM_MISSILES-1:0] shooting_pulse,
  output logic                    ready,
  output logic                    shot_dropped,
  output logic [15:0]             shot_count
);

  localparam int          PW      = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
  localparam logic [PW:0] c_N     = (PW+1)'(NUM_MISSILES);
  localparam logic [7:0]  c_CD    = 8'(COOLDOWN_FRAMES);
  localparam logic [1:0]  c_TO    = 2'(RESERVE_TIMEOUT);

  typedef enum logic [0:0] {
    ST_ARMED    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  state_t                           r_state;
  logic [7:0]                       r_cd_cnt;
  logic [PW-1:0]                    r_rr_ptr;
  logic [NUM_MISSILES-1:0]          r_reserved;
  logic [NUM_MISSILES-1:0][1:0]     r_res_cnt;
  logic                             r_fire_q;
  logic [NUM_MISSILES-1:0]          r_pulse;
  logic                             r_ready;
  logic                             r_dropped;
  logic [15:0]                      r_count;

  logic                             w_request;
  logic [NUM_MISSILES-1:0]          w_free;
  logic                             w_found;
  logic [PW-1:0]                    w_slot;
  logic [PW-1:0]                    w_cand;
  logic                             w_issue;
  logic                             w_drop;
  state_t                           w_state_nxt;
  logic [7:0]                       w_cd_nxt;
  logic [NUM_MISSILES-1:0]          w_reserved_nxt;
  logic [NUM_MISSILES-1:0][1:0]     w_res_cnt_nxt;
  logic [NUM_MISSILES-1:0]          w_pulse_nxt;
  logic                             w_ready_nxt;

  // Reduce (slot + offset) modulo NUM_MISSILES; operand is always < 2*NUM_MISSILES.
  function automatic logic [PW-1:0] f_wrap(input logic [PW:0] v);
    if (v >= c_N) return PW'(v - c_N);
    return v[PW-1:0];
  endfunction

  assign w_request = (AUTO_FIRE != 0) ? fire_req : (fire_req && !r_fire_q);
  assign w_free    = ~missile_active & ~r_reserved;
  assign w_issue   = enable && (r_state == ST_ARMED) && w_request && w_found;
  assign w_drop    = enable && (r_state == ST_ARMED) && w_request && !w_found;

  always_comb begin
    w_found = 1'b0;
    w_slot  = '0;
    w_cand  = '0;
    for (int j = 0; j < NUM_MISSILES; j++) begin
      w_cand = f_wrap({1'b0, r_rr_ptr} + (PW+1)'(j));
      if (!w_found && w_free[w_cand]) begin
        w_found = 1'b1;
        w_slot  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cd_nxt       = r_cd_cnt;
    w_reserved_nxt = r_reserved;
    w_res_cnt_nxt  = r_res_cnt;
    w_pulse_nxt    = '0;

    // A fresh launch overrides aging so its timeout starts at the next frame.
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (w_issue && (w_slot == PW'(i))) begin
        w_reserved_nxt[i] = 1'b1;
        w_res_cnt_nxt[i]  = 2'd0;
      end else if (missile_active[i]) begin
        w_reserved_nxt[i] = 1'b0;
        w_res_cnt_nxt[i]  = 2'd0;
      end else if (r_reserved[i] && startOfFrame) begin
        if (r_res_cnt[i] + 2'd1 == c_TO) begin
          w_reserved_nxt[i] = 1'b0;
          w_res_cnt_nxt[i]  = 2'd0;
        end else begin
          w_res_cnt_nxt[i]  = r_res_cnt[i] + 2'd1;
        end
      end
    end

    if (!enable) begin
      w_state_nxt = ST_ARMED;
      w_cd_nxt    = 8'd0;
    end else if (w_issue) begin
      w_pulse_nxt[w_slot] = 1'b1;
      w_cd_nxt            = c_CD;
      w_state_nxt         = (COOLDOWN_FRAMES != 0) ? ST_COOLDOWN : ST_ARMED;
    end else if ((r_state == ST_COOLDOWN) && startOfFrame) begin
      if (r_cd_cnt == 8'd1) begin
        w_state_nxt = ST_ARMED;
        w_cd_nxt    = 8'd0;
      end else begin
        w_cd_nxt    = r_cd_cnt - 8'd1;
      end
    end

    w_ready_nxt = (w_state_nxt == ST_ARMED) && enable &&
                  (|(~missile_active & ~w_reserved_nxt));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_ARMED;
      r_cd_cnt   <= 8'd0;
      r_rr_ptr   <= '0;
      r_reserved <= '0;
      r_res_cnt  <= '0;
      r_fire_q   <= 1'b0;
      r_pulse    <= '0;
      r_ready    <= 1'b0;
      r_dropped  <= 1'b0;
      r_count    <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cd_cnt   <= w_cd_nxt;
      r_reserved <= w_reserved_nxt;
      r_res_cnt  <= w_res_cnt_nxt;
      r_fire_q   <= fire_req;
      r_pulse    <= w_pulse_nxt;
      r_ready    <= w_ready_nxt;
      r_dropped  <= w_drop;
      if (w_issue) begin
        r_rr_ptr <= f_wrap({1'b0, w_slot} + (PW+1)'(1));
        r_count  <= r_count + 16'd1;
      end
    end
  end

  assign shooting_pulse = r_pulse;
  assign ready          = r_ready;
  assign shot_dropped   = r_dropped;
  assign shot_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_missile_fire_controller.sv
// ============================================================================
// Module   : tb_missile_fire_controller
// Purpose  : Self-checking bench for missile_fire_controller in three configs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_missile_fire_controller;

  typedef struct packed {
    logic        sof;
    logic        en;
    logic        fire;
    logic [3:0]  act;
    logic [3:0]  pulse;
    logic        rdy;
    logic        drp;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: no cooldown, edge fire
  logic       rst_a = 1'b0, sof_a = 1'b0, en_a = 1'b1, fire_a = 1'b0;
  logic [3:0] act_a = 4'b0000, pulse_a;
  logic       rdy_a, drp_a;
  logic [15:0] cnt_a;
  // Instance B: default 8-frame cooldown, edge fire
  logic       rst_b = 1'b0, sof_b = 1'b0, en_b = 1'b1, fire_b = 1'b0;
  logic [3:0] act_b = 4'b0000, pulse_b;
  logic       rdy_b, drp_b;
  logic [15:0] cnt_b;
  // Instance C: 3-frame cooldown, auto fire
  logic       rst_c = 1'b0, sof_c = 1'b0, en_c = 1'b1, fire_c = 1'b0;
  logic [3:0] act_c = 4'b0000, pulse_c;
  logic       rdy_c, drp_c;
  logic [15:0] cnt_c;

  missile_fire_controller #(.NUM_MISSILES(4), .COOLDOWN_FRAMES(0), .RESERVE_TIMEOUT(2), .AUTO_FIRE(0)) dut_a (
    .clk(clk), .resetN(rst_a), .startOfFrame(sof_a), .enable(en_a), .fire_req(fire_a),
    .missile_active(act_a), .shooting_pulse(pulse_a), .ready(rdy_a), .shot_dropped(drp_a), .shot_count(cnt_a));

  missile_fire_controller #(.NUM_MISSILES(4), .COOLDOWN_FRAMES(8), .RESERVE_TIMEOUT(2), .AUTO_FIRE(0)) dut_b (
    .clk(clk), .resetN(rst_b), .startOfFrame(sof_b), .enable(en_b), .fire_req(fire_b),
    .missile_active(act_b), .shooting_pulse(pulse_b), .ready(rdy_b), .shot_dropped(drp_b), .shot_count(cnt_b));

  missile_fire_controller #(.NUM_MISSILES(4), .COOLDOWN_FRAMES(3), .RESERVE_TIMEOUT(2), .AUTO_FIRE(1)) dut_c (
    .clk(clk), .resetN(rst_c), .startOfFrame(sof_c), .enable(en_c), .fire_req(fire_c),
    .missile_active(act_c), .shooting_pulse(pulse_c), .ready(rdy_c), .shot_dropped(drp_c), .shot_count(cnt_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic e, input logic f, input logic [3:0] a,
                              input logic [3:0] p, input logic r, input logic d, input logic [15:0] n);
    vec_t v;
    v.sof = s; v.en = e; v.fire = f; v.act = a;
    v.pulse = p; v.rdy = r; v.drp = d; v.cnt = n;
    return v;
  endfunction

  vec_t       tbl [26];
  vec_t       sb_vec [$];
  logic [3:0] sb_pulse [$];

  initial begin
    vec_t       v;
    logic [3:0] ep;
    int         nsof;

    //                 sof   en    fire  act       pulse    rdy   drp   cnt
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, 16'd1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'd1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0010, 1'b1, 1'b0, 16'd2);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000, 1'b1, 1'b0, 16'd2);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0100, 1'b1, 1'b0, 16'd3);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 4'b0111, 4'b0000, 1'b1, 1'b0, 16'd3);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 4'b0111, 4'b1000, 1'b0, 1'b0, 16'd4);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 16'd4);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'd4);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 16'd4);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0, 16'd4);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 4'b1011, 4'b0100, 1'b0, 1'b0, 16'd5);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 16'd5);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 16'd5);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b0, 1'b1, 16'd5);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0, 16'd5);
    tbl[18] = mk(1'b0, 1'b1, 1'b1, 4'b1011, 4'b0100, 1'b0, 1'b0, 16'd6);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd6);
    tbl[20] = mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0, 16'd7);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd7);
    tbl[22] = mk(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'd7);
    tbl[23] = mk(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd7);
    tbl[24] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'd7);
    tbl[25] = mk(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, 16'd8);

    // ---------------- Instance A: reset values, then vector table
    tick();
    tick();
    chk("A reset pulse", 16'(pulse_a), 16'h0);
    chk("A reset ready", 16'(rdy_a), 16'h0);
    chk("A reset drop",  16'(drp_a), 16'h0);
    chk("A reset count", cnt_a, 16'h0);
    rst_a = 1'b1;
    for (int i = 0; i < 26; i++) begin
      sof_a = tbl[i].sof; en_a = tbl[i].en; fire_a = tbl[i].fire; act_a = tbl[i].act;
      sb_vec.push_back(tbl[i]);
      tick();
      v = sb_vec.pop_front();
      chk($sformatf("A[%0d] pulse", i), 16'(pulse_a), 16'(v.pulse));
      chk($sformatf("A[%0d] ready", i), 16'(rdy_a), 16'(v.rdy));
      chk($sformatf("A[%0d] drop", i),  16'(drp_a), 16'(v.drp));
      chk($sformatf("A[%0d] count", i), cnt_a, v.cnt);
    end
    sof_a = 1'b0; fire_a = 1'b0;

    // ---------------- Instance B: first shot with frame pulse in issue cycle
    rst_b = 1'b1;
    tick();
    chk("B ready after reset", 16'(rdy_b), 16'h1);
    repeat (8) tick();
    fire_b = 1'b1; sof_b = 1'b1;
    tick();
    chk("B first pulse", 16'(pulse_b), 16'h1);
    chk("B first count", cnt_b, 16'd1);
    chk("B first ready", 16'(rdy_b), 16'h0);
    nsof = 0;
    for (int c = 0; c < 36; c++) begin
      sof_b = (c % 4 == 3);
      tick();
      if (sof_b) nsof++;
      chk($sformatf("B cd ready c%0d", c), 16'(rdy_b), 16'(nsof >= 8));
      chk($sformatf("B cd pulse c%0d", c), 16'(pulse_b), 16'h0);
    end
    sof_b = 1'b0; fire_b = 1'b0;
    tick();
    for (int s = 2; s <= 5; s++) begin
      fire_b = 1'b1;
      ep = 4'b0001 << ((s - 1) % 4);
      tick();
      chk($sformatf("B shot%0d pulse", s), 16'(pulse_b), 16'(ep));
      chk($sformatf("B shot%0d count", s), cnt_b, 16'(s));
      fire_b = 1'b0;
      if (s < 5) begin
        for (int c = 0; c < 32; c++) begin
          sof_b = (c % 4 == 3);
          tick();
        end
        sof_b = 1'b0;
      end
    end
    // Asynchronous reset while the fifth launch pulse is still high
    #1 rst_b = 1'b0;
    #1;
    chk("B async reset pulse", 16'(pulse_b), 16'h0);
    chk("B async reset ready", 16'(rdy_b), 16'h0);
    chk("B async reset drop",  16'(drp_b), 16'h0);
    chk("B async reset count", cnt_b, 16'h0);
    tick();
    rst_b = 1'b1;
    tick();
    chk("B ready after rearm", 16'(rdy_b), 16'h1);
    fire_b = 1'b1;
    tick();
    chk("B post-reset slot", 16'(pulse_b), 16'h1);
    chk("B post-reset count", cnt_b, 16'd1);
    fire_b = 1'b0;

    // ---------------- Instance C: auto fire held, 3-frame cooldown
    rst_c = 1'b1;
    tick();
    for (int c = 0; c < 26; c++) begin
      fire_c = 1'b1;
      sof_c  = (c % 4 == 2);
      sb_pulse.push_back((c == 0) ? 4'b0001 : (c == 11) ? 4'b0010 : (c == 23) ? 4'b0100 : 4'b0000);
      tick();
      ep = sb_pulse.pop_front();
      chk($sformatf("C pulse c%0d", c), 16'(pulse_c), 16'(ep));
    end
    chk("C count", cnt_c, 16'd3);
    chk("C no drop", 16'(drp_c), 16'h0);
    fire_c = 1'b0; sof_c = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
